// File: rtl/pc_sequencer.sv
// Fetch-loop sequencer for an external 11-bit program counter with increment/load/D strobes.
// Picks the next PC (sequential, jump, call, return) and keeps a small return-address stack.
module pc_sequencer #(
   parameter int                ADDR_W      = 11,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = 11'h000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   output logic              fetch_req,
   input  logic              fetch_ack,
   input  logic              br_jump,
   input  logic              br_call,
   input  logic              br_ret,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] pc_q,
   output logic              pc_increment,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_d,
   output logic              busy,
   output logic              stack_err
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_STROBE = 3'd3;
   localparam logic [2:0] S_SETTLE = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]        state;
   logic [SP_W-1:0]   sp;
   logic              booted;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              underflow;
   logic              overflow;
   logic              do_push;

   // Return address wraps at the top of the address space, same as the counter.
   function automatic logic [ADDR_W-1:0] pc_plus1(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

   assign push_idx = sp[IDX_W-1:0];
   assign top_idx  = sp[IDX_W-1:0] - IDX_W'(1);

   // Return outranks call, so a simultaneous call never checks for overflow.
   always_comb begin
      underflow = 1'b0;
      overflow  = 1'b0;
      if (br_ret)
         underflow = (sp == '0);
      else if (br_call)
         overflow = (sp == SP_W'(STACK_DEPTH));
   end

   assign do_push = (state == S_FETCH) && fetch_ack && !br_ret && br_call && !overflow;

   // Stack contents are pure data; only sp decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push)
         stack[push_idx] <= pc_plus1(pc_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         sp           <= '0;
         booted       <= 1'b0;
         fetch_req    <= 1'b0;
         pc_increment <= 1'b0;
         pc_load      <= 1'b0;
         pc_d         <= '0;
         busy         <= 1'b0;
         stack_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  busy <= 1'b1;
                  if (!booted) begin
                     booted  <= 1'b1;
                     pc_load <= 1'b1;
                     pc_d    <= RESET_VEC;
                     state   <= S_SETUP;
                  end else begin
                     fetch_req <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (fetch_ack) begin
                  fetch_req <= 1'b0;
                  if (underflow || overflow) begin
                     stack_err <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_HALT;
                  end else begin
                     state <= S_SETUP;
                     if (br_ret) begin
                        pc_load <= 1'b1;
                        pc_d    <= stack[top_idx];
                        sp      <= sp - SP_W'(1);
                     end else if (br_call) begin
                        pc_load <= 1'b1;
                        pc_d    <= br_target;
                        sp      <= sp + SP_W'(1);
                     end else if (br_jump) begin
                        pc_load <= 1'b1;
                        pc_d    <= br_target;
                     end else begin
                        pc_load <= 1'b0;
                     end
                  end
               end
            end
            // load/d were settled one cycle earlier, so they are stable across the rising strobe
            S_SETUP: begin
               pc_increment <= 1'b1;
               state        <= S_STROBE;
            end
            S_STROBE: begin
               pc_increment <= 1'b0;
               pc_load      <= 1'b0;
               state        <= S_SETTLE;
            end
            S_SETTLE: begin
               if (run) begin
                  fetch_req <= 1'b1;
                  state     <= S_FETCH;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_HALT: begin
               fetch_req    <= 1'b0;
               pc_increment <= 1'b0;
               pc_load      <= 1'b0;
               busy         <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural PC counter, a fetch responder, and a strobe scoreboard.
// Expected strobes are queued as stimulus is issued; a monitor pops one per observed pulse.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        fetch_req;
   logic        fetch_ack = 1'b0;
   logic        br_jump = 1'b0;
   logic        br_call = 1'b0;
   logic        br_ret = 1'b0;
   logic [10:0] br_target = '0;
   logic [10:0] pc_q = 11'h555;
   logic        pc_increment;
   logic        pc_load;
   logic [10:0] pc_d;
   logic        busy;
   logic        stack_err;

   typedef struct {
      logic        ld;
      logic [10:0] d;
      logic [10:0] pc;
   } strobe_t;

   strobe_t exp_q[$];
   int checks = 0;
   int errors = 0;
   logic prev_inc = 1'b0;

   pc_sequencer dut (
      .clk(clk), .reset_n(reset_n), .run(run),
      .fetch_req(fetch_req), .fetch_ack(fetch_ack),
      .br_jump(br_jump), .br_call(br_call), .br_ret(br_ret), .br_target(br_target),
      .pc_q(pc_q), .pc_increment(pc_increment), .pc_load(pc_load), .pc_d(pc_d),
      .busy(busy), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   // External program counter: acts on the rising edge of the strobe.
   always @(posedge pc_increment)
      pc_q <= pc_load ? pc_d : pc_q + 11'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_strobe(input logic ld, input logic [10:0] d, input logic [10:0] pc);
      strobe_t s;
      s.ld = ld; s.d = d; s.pc = pc;
      exp_q.push_back(s);
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && pc_increment) begin
         if (prev_inc)
            chk("strobe_width", 32'd2, 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {21'd0, pc_q}, 32'hFFFF);
         end else begin
            strobe_t s;
            s = exp_q.pop_front();
            chk("pc_load", {31'd0, pc_load}, {31'd0, s.ld});
            if (s.ld)
               chk("pc_d", {21'd0, pc_d}, {21'd0, s.d});
            chk("pc_q", {21'd0, pc_q}, {21'd0, s.pc});
         end
      end
      prev_inc <= reset_n && pc_increment;
   end

   task automatic fetch(input logic j, input logic c, input logic r, input logic [10:0] tgt);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (fetch_req) seen = 1;
      end
      if (!seen) begin
         chk("fetch_timeout", 32'd0, 32'd1);
      end else begin
         fetch_ack = 1'b1; br_jump = j; br_call = c; br_ret = r; br_target = tgt;
         @(negedge clk);
         fetch_ack = 1'b0; br_jump = 1'b0; br_call = 1'b0; br_ret = 1'b0; br_target = '0;
      end
   endtask

   task automatic wait_strobe();
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (pc_increment) seen = 1;
      end
      if (!seen) chk("strobe_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk(name, {26'd0, fetch_req, pc_increment, pc_load, busy, stack_err, |pc_d}, 32'd0);
   endtask

   task automatic check_halted(input string name);
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fetch_req || pc_increment || busy) bad++;
      end
      chk({name, "_quiet"}, bad, 32'd0);
      chk({name, "_stack_err"}, {31'd0, stack_err}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_outputs_zero("reset_outputs");
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset_outputs_initial");
      reset_n = 1'b1;

      // Boot load of the reset vector, then sequential fetches
      expect_strobe(1'b1, 11'h000, 11'h000);
      run = 1'b1;
      expect_strobe(1'b0, 11'h000, 11'h001); fetch(0, 0, 0, 11'h000);
      expect_strobe(1'b0, 11'h000, 11'h002); fetch(0, 0, 0, 11'h000);
      expect_strobe(1'b0, 11'h000, 11'h003); fetch(0, 0, 0, 11'h000);
      drain();
      // run dropped: back to IDLE, and resuming does not reload the reset vector
      run = 1'b0;
      repeat (6) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_fetch_req", {31'd0, fetch_req}, 32'd0);
      run = 1'b1;

      // Wrap at the top of the address space
      expect_strobe(1'b1, 11'h7FE, 11'h7FE); fetch(1, 0, 0, 11'h7FE);
      expect_strobe(1'b0, 11'h000, 11'h7FF); fetch(0, 0, 0, 11'h000);
      expect_strobe(1'b0, 11'h000, 11'h000); fetch(0, 0, 0, 11'h000);
      drain();
      chk("wrap_no_stack_err", {31'd0, stack_err}, 32'd0);

      // Call and return
      expect_strobe(1'b1, 11'h010, 11'h010); fetch(1, 0, 0, 11'h010);
      expect_strobe(1'b1, 11'h100, 11'h100); fetch(0, 1, 0, 11'h100);
      expect_strobe(1'b1, 11'h011, 11'h011); fetch(0, 0, 1, 11'h000);

      // Return outranks call and jump; target is ignored
      expect_strobe(1'b1, 11'h200, 11'h200); fetch(0, 1, 0, 11'h200);
      expect_strobe(1'b1, 11'h012, 11'h012); fetch(1, 1, 1, 11'h3FF);

      // Call at 0x7FF pushes 0x000
      expect_strobe(1'b1, 11'h7FF, 11'h7FF); fetch(1, 0, 0, 11'h7FF);
      expect_strobe(1'b1, 11'h100, 11'h100); fetch(0, 1, 0, 11'h100);
      expect_strobe(1'b1, 11'h000, 11'h000); fetch(0, 0, 1, 11'h000);

      // Four nested calls fill the stack, the fifth overflows
      expect_strobe(1'b1, 11'h020, 11'h020); fetch(0, 1, 0, 11'h020);
      expect_strobe(1'b1, 11'h030, 11'h030); fetch(0, 1, 0, 11'h030);
      expect_strobe(1'b1, 11'h040, 11'h040); fetch(0, 1, 0, 11'h040);
      expect_strobe(1'b1, 11'h050, 11'h050); fetch(0, 1, 0, 11'h050);
      fetch(0, 1, 0, 11'h060);
      check_halted("overflow");
      chk("overflow_pc_held", {21'd0, pc_q}, 32'h050);
      drain();

      // Return on an empty stack after reset
      do_reset();
      expect_strobe(1'b1, 11'h000, 11'h000);
      fetch(0, 0, 1, 11'h000);
      check_halted("underflow");
      drain();

      // Reset in the middle of a strobe
      do_reset();
      expect_strobe(1'b1, 11'h000, 11'h000);
      expect_strobe(1'b0, 11'h000, 11'h001);
      fetch(0, 0, 0, 11'h000);
      wait_strobe();
      #1 reset_n = 1'b0;
      #1 chk_outputs_zero("reset_mid_strobe");
      @(negedge clk);
      expect_strobe(1'b1, 11'h000, 11'h000);
      reset_n = 1'b1;
      drain();
      expect_strobe(1'b0, 11'h000, 11'h001); fetch(0, 0, 0, 11'h000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
